// File: rtl/hsid_dist_search.sv
// Streams meas/ref band-word pairs, accumulates SSD or SAD per library pixel, tracks min/max match.
// Result registered 2 edges after a pixel's last beat; in_ready is high only in RUN, input stalls on in_valid gaps.
module hsid_dist_search #(
  parameter int DATA_WIDTH        = 16,
  parameter int WORD_WIDTH        = 32,
  parameter int BANDS_PER_WORD    = WORD_WIDTH / DATA_WIDTH,
  parameter int HSP_BANDS_WIDTH   = 8,
  parameter int HSP_LIBRARY_WIDTH = 11,
  parameter int ACC_WIDTH         = 3 * DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         clear,
  input  logic                         mode,
  input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands,
  input  logic [HSP_LIBRARY_WIDTH-1:0] library_size,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_WIDTH-1:0]        in_meas,
  input  logic [WORD_WIDTH-1:0]        in_ref,
  output logic                         dist_valid,
  output logic [ACC_WIDTH-1:0]         dist_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] dist_index,
  output logic [ACC_WIDTH-1:0]         min_dist,
  output logic [ACC_WIDTH-1:0]         max_dist,
  output logic [HSP_LIBRARY_WIDTH-1:0] min_index,
  output logic [HSP_LIBRARY_WIDTH-1:0] max_index,
  output logic                         busy,
  output logic                         done,
  output logic                         sat,
  output logic                         cfg_err
);

  localparam int TW   = 2 * DATA_WIDTH;
  localparam int SUMW = TW + $clog2(BANDS_PER_WORD) + 1;
  localparam int EW   = ((ACC_WIDTH > SUMW) ? ACC_WIDTH : SUMW) + 1;
  localparam int BIW  = HSP_BANDS_WIDTH + $clog2(BANDS_PER_WORD) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                         r_state;
  state_t                         w_next;
  logic                           r_mode;
  logic [HSP_BANDS_WIDTH-1:0]     r_bands;
  logic [HSP_LIBRARY_WIDTH-1:0]   r_lib;
  logic [HSP_BANDS_WIDTH-1:0]     r_wpp;
  logic [HSP_BANDS_WIDTH-1:0]     r_word_cnt;
  logic [HSP_LIBRARY_WIDTH-1:0]   r_pix_cnt;
  logic                           r_drain_cnt;
  logic                           r_done;
  logic                           r_zero;

  logic                           r_s1_vld;
  logic                           r_s1_first;
  logic                           r_s1_last;
  logic [HSP_LIBRARY_WIDTH-1:0]   r_s1_idx;
  logic [BANDS_PER_WORD-1:0][DATA_WIDTH-1:0] r_s1_diff;
  logic                           r_s2_vld;
  logic                           r_s2_last;
  logic [HSP_LIBRARY_WIDTH-1:0]   r_s2_idx;
  logic [ACC_WIDTH-1:0]           r_acc;

  logic                           w_start_ok;
  logic                           w_start_acc;
  logic                           w_beat;
  logic                           w_last_word;
  logic                           w_last_pix;
  logic [BIW-1:0]                 w_wpp_ext;
  logic [BIW-1:0]                 w_band_base;
  logic [BANDS_PER_WORD-1:0][DATA_WIDTH-1:0] w_diff;
  logic [TW-1:0]                  w_lane;
  logic [TW-1:0]                  w_term;
  logic [SUMW-1:0]                w_sum;
  logic [ACC_WIDTH-1:0]           w_base;
  logic [EW-1:0]                  w_ext;
  logic                           w_ovf;
  logic [ACC_WIDTH-1:0]           w_acc_nxt;

  assign w_start_ok  = start && (hsp_bands != '0) && (library_size != '0);
  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_beat      = (r_state == S_RUN) && in_valid && !clear;
  assign w_last_word = (r_word_cnt == r_wpp - HSP_BANDS_WIDTH'(1));
  assign w_last_pix  = (r_pix_cnt == r_lib - HSP_LIBRARY_WIDTH'(1));
  assign w_wpp_ext   = (BIW'(hsp_bands) + BIW'(BANDS_PER_WORD - 1)) / BIW'(BANDS_PER_WORD);
  assign w_band_base = BIW'(r_word_cnt) * BIW'(BANDS_PER_WORD);
  assign done        = r_done;

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (start) w_next = w_start_ok ? S_RUN : S_DONE;
      S_RUN: begin
        in_ready = 1'b1;
        if (w_beat && w_last_word && w_last_pix) w_next = S_DRAIN;
      end
      S_DRAIN: if (r_drain_cnt) w_next = S_DONE;
      S_DONE:  if (r_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (clear) w_next = S_IDLE;
  end

  // DONE lasts two cycles: first registers the done strobe, second returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_bands     <= '0;
      r_lib       <= '0;
      r_wpp       <= '0;
      r_word_cnt  <= '0;
      r_pix_cnt   <= '0;
      r_drain_cnt <= 1'b0;
      r_done      <= 1'b0;
      r_zero      <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (clear) begin
        r_drain_cnt <= 1'b0;
        r_done      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (start) begin
            r_mode      <= mode;
            r_bands     <= hsp_bands;
            r_lib       <= library_size;
            r_wpp       <= HSP_BANDS_WIDTH'(w_wpp_ext);
            r_word_cnt  <= '0;
            r_pix_cnt   <= '0;
            r_drain_cnt <= 1'b0;
            r_zero      <= !w_start_ok;
            cfg_err     <= 1'b0;
          end
          S_RUN: if (w_beat) begin
            if (w_last_word) begin
              r_word_cnt <= '0;
              r_pix_cnt  <= r_pix_cnt + HSP_LIBRARY_WIDTH'(1);
            end else begin
              r_word_cnt <= r_word_cnt + HSP_BANDS_WIDTH'(1);
            end
          end
          S_DRAIN: r_drain_cnt <= 1'b1;
          S_DONE: begin
            r_done <= !r_done;
            if (!r_done && r_zero) cfg_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Lanes past the pixel's band count are zeroed here so they add nothing downstream.
  always_comb begin
    w_diff = '0;
    for (int k = 0; k < BANDS_PER_WORD; k++) begin
      if ((w_band_base + BIW'(k)) < BIW'(r_bands)) begin
        if (in_meas[k*DATA_WIDTH +: DATA_WIDTH] > in_ref[k*DATA_WIDTH +: DATA_WIDTH])
          w_diff[k] = in_meas[k*DATA_WIDTH +: DATA_WIDTH] - in_ref[k*DATA_WIDTH +: DATA_WIDTH];
        else
          w_diff[k] = in_ref[k*DATA_WIDTH +: DATA_WIDTH] - in_meas[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_sum  = '0;
    w_lane = '0;
    w_term = '0;
    for (int k = 0; k < BANDS_PER_WORD; k++) begin
      w_lane = TW'(r_s1_diff[k]);
      w_term = r_mode ? w_lane : w_lane * w_lane;
      w_sum  = w_sum + SUMW'(w_term);
    end
  end

  assign w_base    = r_s1_first ? '0 : r_acc;
  assign w_ext     = EW'(w_base) + EW'(w_sum);
  assign w_ovf     = |w_ext[EW-1:ACC_WIDTH];
  assign w_acc_nxt = w_ovf ? '1 : w_ext[ACC_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_diff  <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_idx   <= '0;
      r_acc      <= '0;
      dist_valid <= 1'b0;
      dist_value <= '0;
      dist_index <= '0;
      min_dist   <= '0;
      max_dist   <= '0;
      min_index  <= '0;
      max_index  <= '0;
      sat        <= 1'b0;
    end else if (clear) begin
      r_s1_vld   <= 1'b0;
      r_s2_vld   <= 1'b0;
      dist_valid <= 1'b0;
    end else begin
      r_s1_vld <= w_beat;
      if (w_beat) begin
        r_s1_diff  <= w_diff;
        r_s1_first <= (r_word_cnt == '0);
        r_s1_last  <= w_last_word;
        r_s1_idx   <= r_pix_cnt;
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_acc     <= w_acc_nxt;
        r_s2_last <= r_s1_last;
        r_s2_idx  <= r_s1_idx;
        if (w_ovf) sat <= 1'b1;
      end
      dist_valid <= r_s2_vld && r_s2_last;
      if (r_s2_vld && r_s2_last) begin
        dist_value <= r_acc;
        dist_index <= r_s2_idx;
        if (r_s2_idx == '0) begin
          min_dist  <= r_acc;
          max_dist  <= r_acc;
          min_index <= '0;
          max_index <= '0;
        end else begin
          if (r_acc < min_dist) begin
            min_dist  <= r_acc;
            min_index <= r_s2_idx;
          end
          if (r_acc > max_dist) begin
            max_dist  <= r_acc;
            max_index <= r_s2_idx;
          end
        end
      end
      if (w_start_acc) begin
        sat <= 1'b0;
        if (w_start_ok) begin
          min_dist  <= '0;
          max_dist  <= '0;
          min_index <= '0;
          max_index <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hsid_dist_search.sv
// Randomized bench for hsid_dist_search: behavioural distance model, directed control-path cases.
module tb_hsid_dist_search;

  localparam longint unsigned MAX_A = (64'd1 << 48) - 64'd1;
  localparam longint unsigned MAX_B = (64'd1 << 20) - 64'd1;

  logic        clk, rst_n, start, clear, mode, in_valid;
  logic [7:0]  hsp_bands;
  logic [10:0] library_size;
  logic [31:0] in_meas, in_ref;

  logic        in_ready_a, dist_valid_a, busy_a, done_a, sat_a, cfg_err_a;
  logic [47:0] dist_value_a, min_dist_a, max_dist_a;
  logic [10:0] dist_index_a, min_index_a, max_index_a;
  logic        in_ready_b, dist_valid_b, busy_b, done_b, sat_b, cfg_err_b;
  logic [19:0] dist_value_b, min_dist_b, max_dist_b;
  logic [10:0] dist_index_b, min_index_b, max_index_b;

  hsid_dist_search dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .mode(mode),
    .hsp_bands(hsp_bands), .library_size(library_size),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_meas(in_meas), .in_ref(in_ref),
    .dist_valid(dist_valid_a), .dist_value(dist_value_a), .dist_index(dist_index_a),
    .min_dist(min_dist_a), .max_dist(max_dist_a), .min_index(min_index_a), .max_index(max_index_a),
    .busy(busy_a), .done(done_a), .sat(sat_a), .cfg_err(cfg_err_a)
  );

  hsid_dist_search #(.ACC_WIDTH(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .mode(mode),
    .hsp_bands(hsp_bands), .library_size(library_size),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_meas(in_meas), .in_ref(in_ref),
    .dist_valid(dist_valid_b), .dist_value(dist_value_b), .dist_index(dist_index_b),
    .min_dist(min_dist_b), .max_dist(max_dist_b), .min_index(min_index_b), .max_index(max_index_b),
    .busy(busy_b), .done(done_b), .sat(sat_b), .cfg_err(cfg_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_dv, n_done;

  logic [15:0] meas_b [256];
  logic [15:0] lib_b  [8][256];
  logic [15:0] junk_m, junk_r;
  longint unsigned exp_a [8];
  longint unsigned exp_b [8];
  int  min_i, max_i;
  bit  sat_a_e, sat_b_e;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (dist_valid_a) begin
      chk_eq("dv_index", 64'(dist_index_a), 64'(n_dv));
      chk_eq("dv_value", 64'(dist_value_a), exp_a[n_dv & 7]);
      chk_eq("dv_value_acc20", 64'(dist_value_b), exp_b[n_dv & 7]);
      n_dv++;
    end
    if (done_a) n_done++;
  endtask

  // Reference: per-pixel sum over real bands only, saturated to the accumulator range.
  task automatic model(input bit md, input int bands, input int lib);
    longint unsigned tot, d;
    sat_a_e = 1'b0;
    sat_b_e = 1'b0;
    for (int p = 0; p < lib; p++) begin
      tot = 0;
      for (int b = 0; b < bands; b++) begin
        d = (meas_b[b] > lib_b[p][b]) ? 64'(meas_b[b]) - 64'(lib_b[p][b])
                                      : 64'(lib_b[p][b]) - 64'(meas_b[b]);
        tot += md ? d : d * d;
      end
      exp_a[p] = (tot > MAX_A) ? MAX_A : tot;
      exp_b[p] = (tot > MAX_B) ? MAX_B : tot;
      if (tot > MAX_A) sat_a_e = 1'b1;
      if (tot > MAX_B) sat_b_e = 1'b1;
    end
    min_i = 0;
    max_i = 0;
    for (int p = 1; p < lib; p++) begin
      if (exp_a[p] < exp_a[min_i]) min_i = p;
      if (exp_a[p] > exp_a[max_i]) max_i = p;
    end
  endtask

  task automatic drive_word(input int p, input int w, input int bands);
    for (int k = 0; k < 2; k++) begin
      if (w * 2 + k < bands) begin
        in_meas[k*16 +: 16] = meas_b[w*2+k];
        in_ref[k*16 +: 16]  = lib_b[p][w*2+k];
      end else begin
        in_meas[k*16 +: 16] = junk_m;
        in_ref[k*16 +: 16]  = junk_r;
      end
    end
  endtask

  task automatic fill_rand(input int bands, input int lib);
    for (int b = 0; b < bands; b++) meas_b[b] = 16'($urandom);
    for (int p = 0; p < lib; p++)
      for (int b = 0; b < bands; b++) lib_b[p][b] = 16'($urandom);
    junk_m = 16'($urandom);
    junk_r = 16'($urandom);
  endtask

  task automatic run_job(input bit md, input int bands, input int lib, input int gap_pct);
    int  wpp, p, w, cyc;
    bit  beat;
    model(md, bands, lib);
    n_dv = 0;
    n_done = 0;
    wpp = (bands + 1) / 2;
    mode = md;
    hsp_bands = 8'(bands);
    library_size = 11'(lib);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_eq("busy_at_start", 64'(busy_a), 64'd1);
    chk_eq("ready_at_start", 64'(in_ready_a), 64'd1);
    p = 0;
    w = 0;
    cyc = 0;
    while (p < lib && cyc < 4000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      if (in_valid) drive_word(p, w, bands);
      else begin
        in_meas = $urandom;
        in_ref  = $urandom;
      end
      beat = in_valid && in_ready_a;
      step();
      cyc++;
      if (beat) begin
        w++;
        if (w == wpp) begin
          w = 0;
          p++;
        end
      end
    end
    in_valid = 1'b0;
    chk_eq("pixels_accepted", 64'(p), 64'(lib));
    chk_eq("ready_after_last", 64'(in_ready_a), 64'd0);
    step();
    step();
    chk_eq("final_dv_t2", 64'(dist_valid_a), 64'd1);
    step();
    chk_eq("done_t3", 64'(done_a), 64'd1);
    step();
    chk_eq("busy_low_t4", 64'(busy_a), 64'd0);
    chk_eq("dv_count", 64'(n_dv), 64'(lib));
    chk_eq("done_count", 64'(n_done), 64'd1);
    chk_eq("min_dist", 64'(min_dist_a), exp_a[min_i]);
    chk_eq("min_index", 64'(min_index_a), 64'(min_i));
    chk_eq("max_dist", 64'(max_dist_a), exp_a[max_i]);
    chk_eq("max_index", 64'(max_index_a), 64'(max_i));
    chk_eq("sat", 64'(sat_a), 64'(sat_a_e));
    chk_eq("sat_acc20", 64'(sat_b), 64'(sat_b_e));
    chk_eq("cfg_err", 64'(cfg_err_a), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    mode = 1'b0;
    in_valid = 1'b0;
    hsp_bands = '0;
    library_size = '0;
    in_meas = '0;
    in_ref = '0;
    junk_m = '0;
    junk_r = '0;
    n_dv = 0;
    n_done = 0;
    step();
    step();
    chk_eq("rst_busy", 64'(busy_a), 64'd0);
    chk_eq("rst_ready", 64'(in_ready_a), 64'd0);
    chk_eq("rst_done", 64'(done_a), 64'd0);
    chk_eq("rst_dv", 64'(dist_valid_a), 64'd0);
    chk_eq("rst_min", 64'(min_dist_a), 64'd0);
    chk_eq("rst_max_idx", 64'(max_index_a), 64'd0);
    rst_n = 1'b1;
    step();

    // Saturating run on the 20-bit accumulator, then a run that must clear sat.
    meas_b[0] = 16'hFFFF; meas_b[1] = 16'hFFFF;
    lib_b[0][0] = 16'h0;  lib_b[0][1] = 16'h0;
    run_job(1'b0, 2, 1, 0);
    chk_eq("sat_acc20_value", 64'(dist_value_b), 64'hFFFFF);

    for (int b = 0; b < 4; b++) begin
      meas_b[b] = 16'd10;
      lib_b[0][b] = 16'd12;
      lib_b[1][b] = 16'd10;
      lib_b[2][b] = 16'd7;
    end
    run_job(1'b0, 4, 3, 0);
    run_job(1'b1, 4, 3, 0);
    run_job(1'b1, 4, 3, 40);

    // Three bands: lane 1 of word 1 carries extreme junk that must be masked.
    for (int b = 0; b < 3; b++) begin
      meas_b[b] = 16'd100;
      lib_b[0][b] = 16'd101;
    end
    junk_m = 16'hFFFF;
    junk_r = 16'h0000;
    run_job(1'b0, 3, 1, 0);

    meas_b[0] = 16'd5;
    lib_b[0][0] = 16'd0;
    lib_b[1][0] = 16'd0;
    run_job(1'b1, 1, 2, 0);

    // Zero band count: cfg_err and done one edge after start, no input accepted.
    n_done = 0;
    in_valid = 1'b1;
    hsp_bands = 8'd0;
    library_size = 11'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_eq("zc_ready_s", 64'(in_ready_a), 64'd0);
    chk_eq("zc_busy_s", 64'(busy_a), 64'd1);
    step();
    chk_eq("zc_cfg_err", 64'(cfg_err_a), 64'd1);
    chk_eq("zc_done", 64'(done_a), 64'd1);
    chk_eq("zc_ready_s1", 64'(in_ready_a), 64'd0);
    step();
    chk_eq("zc_idle", 64'(busy_a), 64'd0);
    chk_eq("zc_done_once", 64'(done_a), 64'd0);
    in_valid = 1'b0;

    // Clear in the middle of pixel 1.
    fill_rand(4, 3);
    n_dv = 0;
    n_done = 0;
    mode = 1'b0;
    hsp_bands = 8'd4;
    library_size = 11'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      drive_word(i / 2, i % 2, 4);
      step();
    end
    in_valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_eq("clr_idle", 64'(busy_a), 64'd0);
    for (int i = 0; i < 6; i++) step();
    chk_eq("clr_no_dv", 64'(n_dv), 64'd0);
    chk_eq("clr_no_done", 64'(n_done), 64'd0);

    // Asynchronous reset mid-run.
    fill_rand(2, 4);
    for (int b = 0; b < 2; b++) lib_b[0][b] = meas_b[b] ^ 16'h0100;
    model(1'b1, 2, 4);
    n_dv = 0;
    n_done = 0;
    mode = 1'b1;
    hsp_bands = 8'd2;
    library_size = 11'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      drive_word(i, 0, 2);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_busy", 64'(busy_a), 64'd0);
    chk_eq("arst_ready", 64'(in_ready_a), 64'd0);
    chk_eq("arst_dv", 64'(dist_valid_a), 64'd0);
    chk_eq("arst_value", 64'(dist_value_a), 64'd0);
    chk_eq("arst_min", 64'(min_dist_a), 64'd0);
    chk_eq("arst_max", 64'(max_dist_a), 64'd0);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk_eq("arst_no_done", 64'(n_done), 64'd0);

    fill_rand(255, 2);
    run_job(1'($urandom), 255, 2, 10);
    for (int it = 0; it < 25; it++) begin
      int bands, lib;
      bands = $urandom_range(20, 1);
      lib = $urandom_range(8, 1);
      fill_rand(bands, lib);
      if ($urandom_range(3) == 0) lib_b[lib-1] = lib_b[0];
      run_job(1'($urandom), bands, lib, $urandom_range(50));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
